// File: rtl/run_detector.sv
// run_detector: serial "N in a row" qualifier with entry pulse and saturating run length.
// Optional feature macro: EVT_CNT_EN (adds a wrapping detection-event counter on evt_cnt_o).
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-high reset
//   en_i         sample strobe; in_i is sampled only when high
//   in_i         serial data bit
//   pol_i        match polarity (1 = count ones, 0 = count zeros)
//   clr_i        synchronous clear of the run state
//   out_o        high while in DETECT
//   det_pulse_o  one-cycle pulse on entry to DETECT
//   run_len_o    current consecutive-match count, saturating at all-ones
//   evt_cnt_o    number of DETECT entries (constant 0 without EVT_CNT_EN)
module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int EVT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             in_i,
  input  logic             pol_i,
  input  logic             clr_i,
  output logic             out_o,
  output logic             det_pulse_o,
  output logic [CNT_W-1:0] run_len_o,
  output logic [EVT_W-1:0] evt_cnt_o
);
  typedef enum logic [1:0] {IDLE, COUNT, DETECT} state_t;
  localparam logic [CNT_W-1:0] TARGET = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d, inc, sat;
  logic             pulse_q, pulse_d, match;
  assign match = in_i == pol_i;
  assign inc   = run_q + ONE;
  assign sat   = &run_q ? run_q : inc;
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clr_i) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (en_i) begin
          state_d = match ? (TARGET == ONE ? DETECT : COUNT) : IDLE;
          run_d   = match ? ONE : '0;
        end
        COUNT: if (en_i) begin
          state_d = !match ? IDLE : (inc == TARGET ? DETECT : COUNT);
          run_d   = match ? inc : '0;
        end
        DETECT: if (en_i) begin
          state_d = match ? DETECT : IDLE;
          run_d   = match ? sat : '0;
        end
        // unreachable encoding recovers to IDLE regardless of en
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end
  assign pulse_d = (state_d == DETECT) && (state_q != DETECT);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      run_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
    end
  end
  assign out_o       = state_q == DETECT;
  assign det_pulse_o = pulse_q;
  assign run_len_o   = run_q;
`ifdef EVT_CNT_EN
  logic [EVT_W-1:0] evt_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) evt_q <= '0;
    else if (pulse_d) evt_q <= evt_q + EVT_W'(1);
  end
  assign evt_cnt_o = evt_q;
`else
  assign evt_cnt_o = '0;
`endif
endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: randomized and directed checks of three run_detector configurations against a streak model.
module tb_run_detector;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, in = 1'b0, pol = 1'b1, clr = 1'b0;
  logic       out_w [3];
  logic       pul_w [3];
  logic [7:0] run_w [3];
  logic [15:0] evt_w [3];
  logic [2:0] run2;
  int total = 0, bad = 0;
  int streak = 0;
  int rl [3] = '{4, 1, 4};
  int mx [3] = '{255, 255, 7};
  bit pe [3];
  int evt_m [3];

  always #5 clk = ~clk;

  run_detector u0 (.clk_i(clk), .reset_i(reset), .en_i(en), .in_i(in), .pol_i(pol), .clr_i(clr),
    .out_o(out_w[0]), .det_pulse_o(pul_w[0]), .run_len_o(run_w[0]), .evt_cnt_o(evt_w[0]));
  run_detector #(.RUN_LEN(1)) u1 (.clk_i(clk), .reset_i(reset), .en_i(en), .in_i(in), .pol_i(pol), .clr_i(clr),
    .out_o(out_w[1]), .det_pulse_o(pul_w[1]), .run_len_o(run_w[1]), .evt_cnt_o(evt_w[1]));
  run_detector #(.RUN_LEN(4), .CNT_W(3)) u2 (.clk_i(clk), .reset_i(reset), .en_i(en), .in_i(in), .pol_i(pol), .clr_i(clr),
    .out_o(out_w[2]), .det_pulse_o(pul_w[2]), .run_len_o(run2), .evt_cnt_o(evt_w[2]));
  assign run_w[2] = {5'b0, run2};

  function automatic logic [7:0] exp_run(int k);
    return 8'((streak > mx[k]) ? mx[k] : streak);
  endfunction

  function automatic logic [15:0] exp_evt(int k);
`ifdef EVT_CNT_EN
    return 16'(evt_m[k]);
`else
    return 16'(k - k);
`endif
  endfunction

  // one clock edge with the given inputs; the model tracks an unbounded streak of matches
  task automatic step(input bit e, input bit d, input bit p, input bit c);
    en = e; in = d; pol = p; clr = c;
    @(posedge clk);
    if (c) streak = 0;
    else if (e) streak = (d == p) ? streak + 1 : 0;
    for (int k = 0; k < 3; k++) begin
      pe[k] = !c && e && (d == p) && (streak == rl[k]);
      if (pe[k]) evt_m[k] = (evt_m[k] + 1) % 65536;
    end
    #1;
  endtask

  task automatic model_reset();
    streak = 0;
    for (int k = 0; k < 3; k++) begin pe[k] = 1'b0; evt_m[k] = 0; end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_w[k] !== 1'b0) begin bad++; $display("FAIL reset_out[%0d] got=%b exp=0", k, out_w[k]); end
      total++; if (pul_w[k] !== 1'b0) begin bad++; $display("FAIL reset_pulse[%0d] got=%b exp=0", k, pul_w[k]); end
      total++; if (run_w[k] !== 8'd0) begin bad++; $display("FAIL reset_run[%0d] got=%0d exp=0", k, run_w[k]); end
      total++; if (evt_w[k] !== 16'd0) begin bad++; $display("FAIL reset_evt[%0d] got=%0d exp=0", k, evt_w[k]); end
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_run();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++; if (out_w[k] !== (streak >= rl[k])) begin bad++; $display("FAIL run_out[%0d] edge=%0d got=%b exp=%b", k, i, out_w[k], streak >= rl[k]); end
        total++; if (pul_w[k] !== pe[k]) begin bad++; $display("FAIL run_pulse[%0d] edge=%0d got=%b exp=%b", k, i, pul_w[k], pe[k]); end
        total++; if (run_w[k] !== exp_run(k)) begin bad++; $display("FAIL run_len[%0d] edge=%0d got=%0d exp=%0d", k, i, run_w[k], exp_run(k)); end
      end
      if (i == 4) begin
        total++; if ({out_w[0], pul_w[0], run_w[0]} !== {2'b11, 8'd4}) begin bad++; $display("FAIL run_edge4 got=%b%b/%0d exp=11/4", out_w[0], pul_w[0], run_w[0]); end
      end
      if (i == 7) begin
        total++; if (run_w[0] !== 8'd7 || pul_w[0] !== 1'b0) begin bad++; $display("FAIL run_edge7 got=%0d/%b exp=7/0", run_w[0], pul_w[0]); end
      end
    end
  endtask

  task automatic test_break();
    logic [7:0] seq;
    logic [7:0] want [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    seq = 8'b1110_1111;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[7 - i], 1'b1, 1'b0);
      total++; if (run_w[0] !== want[i]) begin bad++; $display("FAIL break_run edge=%0d got=%0d exp=%0d", i + 1, run_w[0], want[i]); end
      total++; if (out_w[0] !== (i == 7) || pul_w[0] !== (i == 7)) begin bad++; $display("FAIL break_out edge=%0d got=%b%b exp=%b", i + 1, out_w[0], pul_w[0], i == 7); end
      for (int k = 1; k < 3; k++) begin
        total++; if (out_w[k] !== (streak >= rl[k]) || pul_w[k] !== pe[k] || run_w[k] !== exp_run(k)) begin bad++; $display("FAIL break_model[%0d] got=%b%b/%0d exp=%b%b/%0d", k, out_w[k], pul_w[k], run_w[k], streak >= rl[k], pe[k], exp_run(k)); end
      end
    end
  endtask

  task automatic test_strobe();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(i % 2 == 0, 1'b1, 1'b1, 1'b0);
      total++; if (run_w[0] !== 8'((i + 2) / 2)) begin bad++; $display("FAIL strobe_run edge=%0d got=%0d exp=%0d", i + 1, run_w[0], (i + 2) / 2); end
      total++; if (out_w[0] !== (i == 6)) begin bad++; $display("FAIL strobe_out edge=%0d got=%b exp=%b", i + 1, out_w[0], i == 6); end
      total++; if (pul_w[0] !== pe[0]) begin bad++; $display("FAIL strobe_pulse edge=%0d got=%b exp=%b", i + 1, pul_w[0], pe[0]); end
    end
  endtask

  task automatic test_pol();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i == 4, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++; if (out_w[k] !== (streak >= rl[k]) || pul_w[k] !== pe[k] || run_w[k] !== exp_run(k)) begin bad++; $display("FAIL pol_model[%0d] edge=%0d got=%b%b/%0d exp=%b%b/%0d", k, i + 1, out_w[k], pul_w[k], run_w[k], streak >= rl[k], pe[k], exp_run(k)); end
      end
    end
    total++; if (out_w[0] !== 1'b0 || run_w[0] !== 8'd0) begin bad++; $display("FAIL pol_drop got=%b/%0d exp=0/0", out_w[0], run_w[0]); end
  endtask

  task automatic test_sat();
    int pulses = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      pulses += int'(pul_w[2]);
      total++; if (run_w[2] !== exp_run(2) || out_w[2] !== (streak >= 4)) begin bad++; $display("FAIL sat_model edge=%0d got=%b/%0d exp=%b/%0d", i + 1, out_w[2], run_w[2], streak >= 4, exp_run(2)); end
    end
    total++; if (run_w[2] !== 8'd7) begin bad++; $display("FAIL sat_hold got=%0d exp=7", run_w[2]); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL sat_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_async_clr();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++; if ({out_w[0], pul_w[0], run_w[0]} !== 10'd0) begin bad++; $display("FAIL async_reset got=%b%b/%0d exp=00/0", out_w[0], pul_w[0], run_w[0]); end
    total++; if (evt_w[0] !== 16'd0) begin bad++; $display("FAIL async_evt got=%0d exp=0", evt_w[0]); end
    @(negedge clk) reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef EVT_CNT_EN
    total++; if (evt_w[0] !== 16'd4) begin bad++; $display("FAIL evt_count got=%0d exp=4", evt_w[0]); end
`endif
    step(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (out_w[0] !== 1'b0 || run_w[0] !== 8'd0 || pul_w[0] !== 1'b0) begin bad++; $display("FAIL clr_state got=%b%b/%0d exp=00/0", out_w[0], pul_w[0], run_w[0]); end
    for (int k = 0; k < 3; k++) begin
      total++; if (evt_w[k] !== exp_evt(k)) begin bad++; $display("FAIL clr_evt[%0d] got=%0d exp=%0d", k, evt_w[k], exp_evt(k)); end
    end
  endtask

  task automatic test_random();
    bit p = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) p = ~p;
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 9) < 8) ? p : ~p, p, $urandom_range(0, 99) == 0);
      for (int k = 0; k < 3; k++) begin
        total++; if (out_w[k] !== (streak >= rl[k])) begin bad++; $display("FAIL rnd_out[%0d] i=%0d got=%b exp=%b", k, i, out_w[k], streak >= rl[k]); end
        total++; if (pul_w[k] !== pe[k]) begin bad++; $display("FAIL rnd_pulse[%0d] i=%0d got=%b exp=%b", k, i, pul_w[k], pe[k]); end
        total++; if (run_w[k] !== exp_run(k)) begin bad++; $display("FAIL rnd_run[%0d] i=%0d got=%0d exp=%0d", k, i, run_w[k], exp_run(k)); end
        total++; if (evt_w[k] !== exp_evt(k)) begin bad++; $display("FAIL rnd_evt[%0d] i=%0d got=%0d exp=%0d", k, i, evt_w[k], exp_evt(k)); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_break();
    test_strobe();
    test_pol();
    test_sat();
    test_async_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
